aria_op_seq: RTL

Command sequencer for the ARIA write buffer. Accepts one L3 operation command (mode, payload size, AAD size), expands it into the ordered phase sequence the write buffer needs, and drives the buffer's command/operation handshake (`cmd_en`, `wr_size`, `wb_op`, `wb_en`, `wb_one`). It sits between the L3 command decoder and the write buffer, with the ARIA CU side in parallel. It reports the active phase so L3 knows which word stream to supply, and signals completion or error.

---
 rtl/aria_pkg.sv | 46 ++++
 rtl/aria_phase_plan.sv | 38 +++
 rtl/aria_op_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aria_pkg.sv
// Shared constants for the ARIA write-buffer command sequencer: mode, buffer op,
// phase and state encodings plus the per-phase plan record.
package aria_pkg;

  localparam logic [2:0] MODE_NM    = 3'b000;
  localparam logic [2:0] MODE_CBC_D = 3'b001;
  localparam logic [2:0] MODE_CMAC  = 3'b010;
  localparam logic [2:0] MODE_CCM   = 3'b011;

  localparam logic [1:0] WB_OP_NM    = 2'b00;
  localparam logic [1:0] WB_OP_CCM_A = 2'b01;
  localparam logic [1:0] WB_OP_CBC_D = 2'b10;
  localparam logic [1:0] WB_OP_CMAC  = 2'b11;

  localparam logic [1:0] PH_NONE = 2'b00;
  localparam logic [1:0] PH_SIZE = 2'b01;
  localparam logic [1:0] PH_AAD  = 2'b10;
  localparam logic [1:0] PH_DATA = 2'b11;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_LOAD  = 5'b00010;
  localparam logic [4:0] ST_ISSUE = 5'b00100;
  localparam logic [4:0] ST_RUN   = 5'b01000;
  localparam logic [4:0] ST_DONE  = 5'b10000;

  localparam logic SEL_SIZE = 1'b0;
  localparam logic SEL_AAD  = 1'b1;

  typedef struct packed {
    logic [1:0] phase;
    logic       last;
    logic [1:0] op;
    logic       size_sel;
  } plan_t;

  // Commands that are accepted but never reach the buffer.
  function automatic logic cmd_is_err(input logic [2:0] mode, input logic [15:0] size);
    logic bad_mode;
    logic empty;
    bad_mode = (mode != MODE_NM) && (mode != MODE_CBC_D) &&
               (mode != MODE_CMAC) && (mode != MODE_CCM);
    empty    = (size == 16'd0) && ((mode == MODE_NM) || (mode == MODE_CBC_D));
    return bad_mode || empty;
  endfunction

endpackage

// File: rtl/aria_phase_plan.sv
// Phase planner: given mode, AAD presence and the current phase, returns the
// next phase with its buffer op, size source and last-phase flag.
module aria_phase_plan import aria_pkg::*; (
  input  logic [2:0] mode,
  input  logic       aad_nz,
  input  logic [1:0] cur_phase,
  output plan_t      plan
);

  always_comb begin
    plan = '{phase: PH_DATA, last: 1'b1, op: WB_OP_NM, size_sel: SEL_SIZE};
    case (mode)
      MODE_CBC_D: plan.op = WB_OP_CBC_D;
      MODE_CMAC:  plan.op = WB_OP_CMAC;
      MODE_CCM: begin
        case (cur_phase)
          // SIZE carries the CCM op so the buffer is already in CCM context.
          PH_NONE: begin
            plan.phase = PH_SIZE;
            plan.last  = 1'b0;
            plan.op    = WB_OP_CCM_A;
          end
          PH_SIZE: begin
            if (aad_nz) begin
              plan.phase    = PH_AAD;
              plan.last     = 1'b0;
              plan.op       = WB_OP_CCM_A;
              plan.size_sel = SEL_AAD;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aria_op_seq.sv
// ARIA write-buffer command sequencer: expands one L3 command into its phase
// sequence and drives the buffer cmd_en / wb_en / wb_one handshake.
module aria_op_seq import aria_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_core,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [2:0]  cmd_mode,
  input  logic [15:0] cmd_size,
  input  logic [15:0] cmd_aad_size,
  output logic        cmd_en,
  output logic [15:0] wr_size,
  output logic [1:0]  wb_op,
  output logic        wb_en,
  output logic        wb_one,
  input  logic        wb_op_rdy,
  input  logic        wb_d_lst,
  input  logic        wb_d_rdy,
  output logic        seq_busy,
  output logic [1:0]  seq_phase,
  output logic        seq_done,
  output logic        seq_err
);

  logic [4:0]  state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [15:0] size_q, size_d;
  logic [15:0] aad_q, aad_d;
  logic [15:0] wr_size_q, wr_size_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  op_q, op_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic        is_idle, is_load, is_issue, is_run, is_done;
  logic [2:0]  plan_mode;
  logic        plan_aad_nz;
  logic [1:0]  plan_cur;
  logic [15:0] plan_size;
  logic        phase_end;
  plan_t       plan;

  assign is_idle  = (state_q == ST_IDLE);
  assign is_load  = (state_q == ST_LOAD);
  assign is_issue = (state_q == ST_ISSUE);
  assign is_run   = (state_q == ST_RUN);
  assign is_done  = (state_q == ST_DONE);

  // In IDLE the planner sees the live command so the first phase loads on acceptance.
  assign plan_mode   = is_idle ? cmd_mode : mode_q;
  assign plan_aad_nz = is_idle ? (cmd_aad_size != 16'd0) : (aad_q != 16'd0);
  assign plan_cur    = is_idle ? PH_NONE : phase_q;

  aria_phase_plan u_plan (
    .mode      (plan_mode),
    .aad_nz    (plan_aad_nz),
    .cur_phase (plan_cur),
    .plan      (plan)
  );

  always_comb begin
    if (plan.size_sel == SEL_AAD) plan_size = is_idle ? cmd_aad_size : aad_q;
    else                          plan_size = is_idle ? cmd_size : size_q;
  end

  // The SIZE phase finishes when the buffer leaves its size state.
  assign phase_end = (phase_q == PH_SIZE) ? wb_op_rdy : (wb_d_lst & wb_d_rdy);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    size_d    = size_q;
    aad_d     = aad_q;
    wr_size_d = wr_size_q;
    phase_d   = phase_q;
    op_d      = op_q;
    last_d    = last_q;
    err_d     = err_q;
    if (clr_core) begin
      state_d   = ST_IDLE;
      wr_size_d = 16'd0;
      phase_d   = PH_NONE;
      op_d      = WB_OP_NM;
      last_d    = 1'b0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_vld) begin
            mode_d = cmd_mode;
            size_d = cmd_size;
            aad_d  = cmd_aad_size;
            if (cmd_is_err(cmd_mode, cmd_size)) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              err_d     = 1'b0;
              state_d   = ST_LOAD;
              phase_d   = plan.phase;
              last_d    = plan.last;
              op_d      = plan.op;
              wr_size_d = plan_size;
            end
          end
        end
        ST_LOAD:  state_d = ST_ISSUE;
        ST_ISSUE: if (wb_op_rdy) state_d = ST_RUN;
        ST_RUN: begin
          if (phase_end) begin
            if (last_q) begin
              state_d   = ST_DONE;
              wr_size_d = 16'd0;
              phase_d   = PH_NONE;
              op_d      = WB_OP_NM;
            end else begin
              state_d   = ST_LOAD;
              phase_d   = plan.phase;
              last_d    = plan.last;
              op_d      = plan.op;
              wr_size_d = plan_size;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_size_q <= 16'd0;
      phase_q   <= PH_NONE;
      op_q      <= WB_OP_NM;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_size_q <= wr_size_d;
      phase_q   <= phase_d;
      op_q      <= op_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  // Latched command fields are pure data and need no reset.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    size_q <= size_d;
    aad_q  <= aad_d;
  end

  assign cmd_rdy   = is_idle & ~rst & ~clr_core;
  assign cmd_en    = is_load;
  assign wr_size   = wr_size_q;
  assign wb_op     = op_q;
  assign wb_en     = is_issue & (phase_q != PH_SIZE) & wb_op_rdy;
  assign wb_one    = is_issue & (phase_q == PH_SIZE) & wb_op_rdy;
  assign seq_busy  = ~is_idle;
  assign seq_phase = (is_load | is_issue | is_run) ? phase_q : PH_NONE;
  assign seq_done  = is_done;
  assign seq_err   = is_done & err_q;

endmodule
